// File: rtl/camera_pkg.sv
// camera_pkg: shared state encoding, exposure limits and readout step decode for the camera controller.
package camera_pkg;

    typedef enum logic [1:0] {IDLE, EXPOSURE, GAP, READOUT} state_e;

    localparam logic [4:0] EXP_RESET_DEF = 5'd8;
    localparam logic [4:0] EXP_MIN_DEF   = 5'd2;
    localparam logic [4:0] EXP_MAX_DEF   = 5'd30;

    localparam logic [2:0] STEP_LAST  = 3'd5;
    localparam logic [2:0] STEP_ROW2  = 3'd3;
    localparam logic [2:0] STEP_ADC_A = 3'd1;
    localparam logic [2:0] STEP_ADC_B = 3'd4;

    typedef struct packed {
        logic start;
        logic expose;
        logic erase;
        logic nre_1;
        logic nre_2;
        logic adc;
    } ctrl_t;

    // Pixel/timer controls as a pure function of where the capture is.
    function automatic ctrl_t decode(input state_e s, input logic [2:0] step);
        ctrl_t c;
        c.start  = (s == EXPOSURE) || (s == READOUT);
        c.expose = (s == EXPOSURE);
        c.erase  = (s == IDLE);
        c.nre_1  = !((s == READOUT) && (step < STEP_ROW2));
        c.nre_2  = !((s == READOUT) && (step >= STEP_ROW2));
        c.adc    = (s == READOUT) && ((step == STEP_ADC_A) || (step == STEP_ADC_B));
        return c;
    endfunction

endpackage

// File: rtl/edge_detect.sv
// edge_detect: 1-bit rising-edge detector; the previous sample is registered, the pulse is combinational.
module edge_detect (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o
);
    logic prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) prev_q <= 1'b0;
        else       prev_q <= d_i;
    end

    assign rise_o = d_i & ~prev_q;
endmodule

// File: rtl/camera_ctrl_fsm.sv
// camera_ctrl_fsm: capture sequencer driving the exposure timer handshake and pixel-array controls.
module camera_ctrl_fsm
    import camera_pkg::*;
#(
    parameter logic [4:0] EXP_RESET = EXP_RESET_DEF,
    parameter logic [4:0] EXP_MIN   = EXP_MIN_DEF,
    parameter logic [4:0] EXP_MAX   = EXP_MAX_DEF
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Init,
    input  logic       Exp_Inc,
    input  logic       Exp_Dec,
    input  logic       Ovf5,
    input  logic       Ovf4,
    output logic       Start,
    output logic [4:0] Exp_Time,
    output logic       Erase,
    output logic       Expose,
    output logic       NRE_1,
    output logic       NRE_2,
    output logic       ADC
);
    logic init_r, inc_r, dec_r;

    edge_detect u_init (.clk_i(Clk), .rst_i(Reset), .d_i(Init),    .rise_o(init_r));
    edge_detect u_inc  (.clk_i(Clk), .rst_i(Reset), .d_i(Exp_Inc), .rise_o(inc_r));
    edge_detect u_dec  (.clk_i(Clk), .rst_i(Reset), .d_i(Exp_Dec), .rise_o(dec_r));

    state_e     state_q, state_d;
    logic [2:0] step_q, step_d;
    logic [4:0] exp_q, exp_d;
    ctrl_t      ctrl_q, ctrl_d;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        exp_d   = exp_q;
        case (state_q)
            IDLE: begin
                if (init_r)                                     state_d = EXPOSURE;
                else if (inc_r && !dec_r && exp_q < EXP_MAX)    exp_d   = exp_q + 5'd1;
                else if (dec_r && !inc_r && exp_q > EXP_MIN)    exp_d   = exp_q - 5'd1;
            end
            EXPOSURE: if (Ovf5) state_d = GAP;
            GAP: begin
                state_d = READOUT;
                step_d  = '0;
            end
            READOUT: if (Ovf4) begin
                state_d = (step_q == STEP_LAST) ? IDLE : READOUT;
                step_d  = (step_q == STEP_LAST) ? 3'd0 : step_q + 3'd1;
            end
            default: begin
                state_d = IDLE;
                step_d  = '0;
            end
        endcase
        // Outputs are registered from the next state so they move on the same edge as the state.
        ctrl_d = decode(state_d, step_d);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            step_q  <= '0;
            exp_q   <= EXP_RESET;
            ctrl_q  <= decode(IDLE, 3'd0);
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            exp_q   <= exp_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign Exp_Time = exp_q;
    assign Start    = ctrl_q.start;
    assign Expose   = ctrl_q.expose;
    assign Erase    = ctrl_q.erase;
    assign NRE_1    = ctrl_q.nre_1;
    assign NRE_2    = ctrl_q.nre_2;
    assign ADC      = ctrl_q.adc;
endmodule
